// File: rtl/compl_sm_conv.sv
// -----------------------------------------------------------------------------
// compl_sm_conv
//
// Multi-channel, two-stage pipelined converter between two's-complement (2C)
// and sign-magnitude (SM) for LDPC LLR / message words. Each beat carries CH
// words of W bits plus a direction select. Words with no exact representation
// in the target format are flagged. A saturating counter accumulates the
// number of 2C->SM clamp events delivered downstream.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_data       CH input words, channel k at [k*W +: W]
//   i_mode       0: 2C -> SM, 1: SM -> 2C (travels with the beat)
//   i_valid      upstream beat valid
//   o_ready      converter can accept a beat (combinational from i_ready)
//   o_data       CH converted words, same packing as i_data
//   o_sat        per channel: 2C input was the most-negative value (clamped)
//   o_nzero      per channel: SM input was negative zero (mapped to 0)
//   o_valid      output beat valid
//   i_ready      downstream accepts the beat
//   i_cnt_clr    synchronous clear of o_sat_cnt (wins over increment)
//   o_sat_cnt    saturating count of o_sat bits delivered on handshakes
//
// The file also holds compl_sm_conv_chk, a checker module with the
// handshake/stability assertions, instantiated by the top.
// -----------------------------------------------------------------------------

module compl_sm_conv_chk #(
   parameter int W  = 11,
   parameter int CH = 4
) (
   input logic            clk,
   input logic            rst_n,
   input logic            o_valid,
   input logic            i_ready,
   input logic            o_ready,
   input logic [CH*W-1:0] o_data,
   input logic [CH-1:0]   o_sat,
   input logic [CH-1:0]   o_nzero
);

   // A stalled output beat must stay presented and unchanged.
   a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (o_valid && !i_ready) |=> (o_valid && $stable(o_data) && $stable(o_sat) && $stable(o_nzero)));

   // Back-pressure upstream only happens when the output itself is stalled.
   a_ready_full: assert property (@(posedge clk) disable iff (!rst_n)
      !o_ready |-> (o_valid && !i_ready));

   // A beat has one mode, so clamp and negative-zero flags never coexist.
   a_flag_excl: assert property (@(posedge clk) disable iff (!rst_n)
      !((|o_sat) && (|o_nzero)));

endmodule

module compl_sm_conv #(
   parameter int W     = 11,
   parameter int CH    = 4,
   parameter int CNT_W = 16
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [CH*W-1:0]    i_data,
   input  logic               i_mode,
   input  logic               i_valid,
   output logic               o_ready,
   output logic [CH*W-1:0]    o_data,
   output logic [CH-1:0]      o_sat,
   output logic [CH-1:0]      o_nzero,
   output logic               o_valid,
   input  logic               i_ready,
   input  logic               i_cnt_clr,
   output logic [CNT_W-1:0]   o_sat_cnt
);

   // Popcount width covers 0..CH; the sum width covers CNT_MAX + CH without wrap.
   localparam int PC_W  = $clog2(CH + 1);
   localparam int SUM_W = CNT_W + PC_W;

   localparam logic [W-1:0]     MIN_WORD = {1'b1, {(W-1){1'b0}}};
   localparam logic [W-1:0]     MAX_SM   = {W{1'b1}};
   localparam logic [W-1:0]     ONE_W    = {{(W-1){1'b0}}, 1'b1};
   localparam logic [W-1:0]     ZERO_W   = {W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   // ---------------------------------------------------------------------------
   // Conversion helpers
   // ---------------------------------------------------------------------------

   // 2C -> SM. The most-negative value has no SM image; it clamps to -(2^(W-1)-1).
   // For any other negative x, -x fits in W-1 bits, so OR-ing the sign in is exact.
   function automatic logic [W-1:0] tc_to_sm(input logic [W-1:0] x, input logic is_min);
      logic [W-1:0] res;
      if (is_min) begin
         res = MAX_SM;
      end else if (x[W-1]) begin
         res = (~x + ONE_W) | MIN_WORD;
      end else begin
         res = x;
      end
      return res;
   endfunction

   // SM -> 2C. Negative zero maps to plain zero.
   function automatic logic [W-1:0] sm_to_tc(input logic [W-1:0] x, input logic is_nzero);
      logic [W-1:0] res;
      if (is_nzero) begin
         res = ZERO_W;
      end else if (x[W-1]) begin
         res = ~{1'b0, x[W-2:0]} + ONE_W;
      end else begin
         res = x;
      end
      return res;
   endfunction

   function automatic logic [PC_W-1:0] popcount(input logic [CH-1:0] v);
      logic [PC_W-1:0] c;
      c = {PC_W{1'b0}};
      for (int k = 0; k < CH; k++) begin
         c = c + PC_W'(v[k]);
      end
      return c;
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt, input logic [PC_W-1:0] inc);
      logic [SUM_W-1:0] sum;
      logic [CNT_W-1:0] res;
      sum = SUM_W'(cnt) + SUM_W'(inc);
      if (sum > SUM_W'(CNT_MAX)) begin
         res = CNT_MAX;
      end else begin
         res = sum[CNT_W-1:0];
      end
      return res;
   endfunction

   // ---------------------------------------------------------------------------
   // Signals
   // ---------------------------------------------------------------------------
   logic               adv1_s;
   logic               adv2_s;
   logic               out_hs_s;
   logic [CH-1:0]      min_det_s;
   logic [CH*W-1:0]    conv_s;

   logic               s1_valid_r;
   logic [CH*W-1:0]    s1_data_r;
   logic               s1_mode_r;
   logic [CH-1:0]      s1_sat_r;
   logic [CH-1:0]      s1_nzero_r;

   logic               s2_valid_r;
   logic [CH*W-1:0]    s2_data_r;
   logic [CH-1:0]      s2_sat_r;
   logic [CH-1:0]      s2_nzero_r;

   logic [CNT_W-1:0]   cnt_r;

   // Stage advance: an empty stage always pulls, so bubbles collapse.
   always_comb begin
      adv2_s   = !s2_valid_r || i_ready;
      adv1_s   = !s1_valid_r || adv2_s;
      out_hs_s = s2_valid_r && i_ready;
   end

   // Per-channel detection of the pattern 1 followed by zeros; its meaning
   // (2C clamp vs SM negative zero) depends on the beat's mode.
   always_comb begin
      min_det_s = {CH{1'b0}};
      for (int k = 0; k < CH; k++) begin
         min_det_s[k] = (i_data[k*W +: W] == MIN_WORD);
      end
   end

   // Stage 1: capture the input beat, its mode and the mode-qualified flags.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_valid_r <= 1'b0;
         s1_data_r  <= {(CH*W){1'b0}};
         s1_mode_r  <= 1'b0;
         s1_sat_r   <= {CH{1'b0}};
         s1_nzero_r <= {CH{1'b0}};
      end else if (adv1_s) begin
         s1_valid_r <= i_valid;
         if (i_valid) begin
            s1_data_r  <= i_data;
            s1_mode_r  <= i_mode;
            s1_sat_r   <= i_mode ? {CH{1'b0}} : min_det_s;
            s1_nzero_r <= i_mode ? min_det_s : {CH{1'b0}};
         end
      end
   end

   // Word conversion on the stage-1 contents, direction chosen per beat.
   always_comb begin
      conv_s = {(CH*W){1'b0}};
      for (int k = 0; k < CH; k++) begin
         if (s1_mode_r) begin
            conv_s[k*W +: W] = sm_to_tc(s1_data_r[k*W +: W], s1_nzero_r[k]);
         end else begin
            conv_s[k*W +: W] = tc_to_sm(s1_data_r[k*W +: W], s1_sat_r[k]);
         end
      end
   end

   // Stage 2: register converted words and flags; holds while stalled.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s2_valid_r <= 1'b0;
         s2_data_r  <= {(CH*W){1'b0}};
         s2_sat_r   <= {CH{1'b0}};
         s2_nzero_r <= {CH{1'b0}};
      end else if (adv2_s) begin
         s2_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            s2_data_r  <= conv_s;
            s2_sat_r   <= s1_sat_r;
            s2_nzero_r <= s1_nzero_r;
         end
      end
   end

   // Clamp-event counter: clear wins over a concurrent delivered beat.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (i_cnt_clr) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (out_hs_s) begin
         cnt_r <= sat_add(cnt_r, popcount(s2_sat_r));
      end
   end

   assign o_ready   = adv1_s;
   assign o_valid   = s2_valid_r;
   assign o_data    = s2_data_r;
   assign o_sat     = s2_sat_r;
   assign o_nzero   = s2_nzero_r;
   assign o_sat_cnt = cnt_r;

   compl_sm_conv_chk #(.W(W), .CH(CH)) u_chk (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_ready (o_ready),
      .o_data  (o_data),
      .o_sat   (o_sat),
      .o_nzero (o_nzero)
   );

endmodule

// File: tb/tb_compl_sm_conv.sv
// -----------------------------------------------------------------------------
// tb_compl_sm_conv
//
// Self-checking bench for compl_sm_conv (W=11, CH=4, CNT_W=4). A behavioural
// model converts words with integer arithmetic, a queue tracks beats in
// flight, and one negedge process compares the DUT against it every cycle.
// Directed beats carry hand-computed literal expectations as well.
// -----------------------------------------------------------------------------

module tb_compl_sm_conv;

   localparam int W     = 11;
   localparam int CH    = 4;
   localparam int CNT_W = 4;
   localparam int NRT   = 1000;

   logic              clk = 1'b0;
   logic              i_rst_n;
   logic [CH*W-1:0]   i_data;
   logic              i_mode;
   logic              i_valid;
   logic              o_ready;
   logic [CH*W-1:0]   o_data;
   logic [CH-1:0]     o_sat;
   logic [CH-1:0]     o_nzero;
   logic              o_valid;
   logic              i_ready;
   logic              i_cnt_clr;
   logic [CNT_W-1:0]  o_sat_cnt;

   compl_sm_conv #(.W(W), .CH(CH), .CNT_W(CNT_W)) dut (
      .i_clk     (clk),
      .i_rst_n   (i_rst_n),
      .i_data    (i_data),
      .i_mode    (i_mode),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .o_data    (o_data),
      .o_sat     (o_sat),
      .o_nzero   (o_nzero),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .i_cnt_clr (i_cnt_clr),
      .o_sat_cnt (o_sat_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int              t;
      logic [CH*W-1:0] d;
      logic [CH-1:0]   s;
      logic [CH-1:0]   nz;
      bit              has_dir;
      logic [CH*W-1:0] dd;
      logic [CH-1:0]   ds;
      logic [CH-1:0]   dnz;
   } exp_t;

   exp_t            q[$];
   int              checks = 0;
   int              errors = 0;
   int              cyc = 0;
   int              cnt_m = 0;
   bit              rdy_rand = 1'b0;
   bit              rdy_dir = 1'b1;
   bit              rnd_rdy = 1'b1;
   bit              dir_en = 1'b0;
   logic [CH*W-1:0] dir_d = '0;
   logic [CH-1:0]   dir_s = '0;
   logic [CH-1:0]   dir_nz = '0;
   bit              stall_prev = 1'b0;
   logic [CH*W-1:0] held_d;
   logic [CH-1:0]   held_s;
   logic [CH-1:0]   held_nz;
   logic [CH*W-1:0] orig[NRT];
   logic [CH*W-1:0] mid[NRT];

   assign i_ready = rdy_rand ? rnd_rdy : rdy_dir;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Word-level reference from the arithmetic meaning of each format.
   function automatic void conv_word(input int x, input bit mode, output int y, output bit sat, output bit nz);
      int half;
      int v;
      int mag;
      half = 1 << (W - 1);
      sat  = 1'b0;
      nz   = 1'b0;
      if (!mode) begin
         v = (x >= half) ? x - 2 * half : x;
         if (v == -half) begin
            y   = half - 1 + half;   // sign set, magnitude clamped to 2^(W-1)-1
            sat = 1'b1;
         end else if (v < 0) begin
            y = half + (-v);
         end else begin
            y = v;
         end
      end else begin
         mag = x % half;
         v   = (x >= half) ? -mag : mag;
         y   = v & (2 * half - 1);
         nz  = (x >= half) && (mag == 0);
      end
   endfunction

   function automatic void conv_beat(input logic [CH*W-1:0] d, input bit mode,
                                     output logic [CH*W-1:0] od, output logic [CH-1:0] s,
                                     output logic [CH-1:0] nz);
      int y;
      bit a;
      bit b;
      od = '0;
      s  = '0;
      nz = '0;
      for (int k = 0; k < CH; k++) begin
         conv_word(int'(d[k*W +: W]), mode, y, a, b);
         od[k*W +: W] = y[W-1:0];
         s[k]  = a;
         nz[k] = b;
      end
   endfunction

   function automatic logic [CH*W-1:0] pack4(input logic [W-1:0] a0, input logic [W-1:0] a1,
                                             input logic [W-1:0] a2, input logic [W-1:0] a3);
      return {a3, a2, a1, a0};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      rnd_rdy = ($urandom_range(0, 2) != 0);
   end

   // Per-cycle comparison against the model, then model update.
   always @(negedge clk) begin
      bit   ev;
      int   pc;
      exp_t e;
      if (i_rst_n) begin
         chk("o_ready", o_ready, (q.size() < 2) || i_ready);
         chk("o_sat_cnt", o_sat_cnt, cnt_m);
         ev = (q.size() > 0) && (cyc >= q[0].t + 2);
         chk("o_valid", o_valid, ev);
         if (o_valid && ev) begin
            chk("o_data", o_data, q[0].d);
            chk("o_sat", o_sat, q[0].s);
            chk("o_nzero", o_nzero, q[0].nz);
            if (q[0].has_dir) begin
               chk("dir_data", o_data, q[0].dd);
               chk("dir_sat", o_sat, q[0].ds);
               chk("dir_nzero", o_nzero, q[0].dnz);
            end
         end
         if (stall_prev) begin
            chk("stall_valid", o_valid, 1'b1);
            chk("stall_data", o_data, held_d);
            chk("stall_flags", {o_sat, o_nzero}, {held_s, held_nz});
         end
         pc = 0;
         if (o_valid && i_ready && q.size() > 0) begin
            e  = q.pop_front();
            pc = $countones(e.s);
         end
         if (i_cnt_clr) begin
            cnt_m = 0;
         end else if (o_valid && i_ready) begin
            cnt_m = (cnt_m + pc > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : cnt_m + pc;
         end
         stall_prev = o_valid && !i_ready;
         held_d  = o_data;
         held_s  = o_sat;
         held_nz = o_nzero;
         if (i_valid && o_ready) begin
            conv_beat(i_data, i_mode, e.d, e.s, e.nz);
            e.t       = cyc;
            e.has_dir = dir_en;
            e.dd      = dir_d;
            e.ds      = dir_s;
            e.dnz     = dir_nz;
            q.push_back(e);
         end
      end
   end

   task automatic send(input logic [CH*W-1:0] d, input bit mode, input bit hd,
                       input logic [CH*W-1:0] dd, input logic [CH-1:0] ds, input logic [CH-1:0] dnz);
      int n;
      bit acc;
      n       = 0;
      i_data  = d;
      i_mode  = mode;
      i_valid = 1'b1;
      dir_en  = hd;
      dir_d   = dd;
      dir_s   = ds;
      dir_nz  = dnz;
      do begin
         @(negedge clk);
         acc = o_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 300);
      chk("send_accept", acc, 1'b1);
      i_valid = 1'b0;
      dir_en  = 1'b0;
   endtask

   task automatic drain();
      int n;
      n        = 0;
      rdy_rand = 1'b0;
      rdy_dir  = 1'b1;
      while (q.size() > 0 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain", q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic clr_cnt();
      i_cnt_clr = 1'b1;
      @(posedge clk);
      #1;
      i_cnt_clr = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [CH*W-1:0] d;
      logic [CH*W-1:0] rt;
      logic [63:0]     r64;
      logic [CH-1:0]   s_tmp;
      logic [CH-1:0]   nz_tmp;
      i_rst_n   = 1'b0;
      i_valid   = 1'b0;
      i_data    = '0;
      i_mode    = 1'b0;
      i_cnt_clr = 1'b0;

      // Reset state.
      #12;
      chk("rst_valid", o_valid, 1'b0);
      chk("rst_data", o_data, '0);
      chk("rst_flags", {o_sat, o_nzero}, '0);
      chk("rst_cnt", o_sat_cnt, '0);
      chk("rst_ready", o_ready, 1'b1);
      @(posedge clk);
      #2;
      i_rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed mode 0 beat with latency check.
      send(pack4(11'h005, 11'h7FB, 11'h7FF, 11'h400), 1'b0, 1'b1,
           pack4(11'h005, 11'h405, 11'h401, 11'h7FF), 4'b1000, 4'b0000);
      @(negedge clk);
      chk("lat_cycle1", o_valid, 1'b0);
      @(negedge clk);
      chk("lat_cycle2", o_valid, 1'b1);
      drain();
      chk("cnt_after_m0", o_sat_cnt, 4'd1);

      // Directed mode 1 beat.
      send(pack4(11'h405, 11'h400, 11'h3FF, 11'h401), 1'b1, 1'b1,
           pack4(11'h7FB, 11'h000, 11'h3FF, 11'h7FF), 4'b0000, 4'b0010);
      drain();
      chk("cnt_after_m1", o_sat_cnt, 4'd1);

      // Round trip: random words through mode 0, model outputs back through mode 1.
      for (int i = 0; i < NRT; i++) begin
         r64 = {$urandom, $urandom};
         d   = r64[CH*W-1:0];
         if ($urandom_range(0, 7) == 0) begin
            d[$urandom_range(0, CH - 1) * W +: W] = 11'h400;
         end
         orig[i] = d;
         conv_beat(d, 1'b0, mid[i], s_tmp, nz_tmp);
      end
      for (int i = 0; i < NRT; i++) begin
         send(orig[i], 1'b0, 1'b0, '0, '0, '0);
      end
      for (int i = 0; i < NRT; i++) begin
         rt = orig[i];
         for (int k = 0; k < CH; k++) begin
            if (rt[k*W +: W] == 11'h400) begin
               rt[k*W +: W] = 11'h401;
            end
         end
         send(mid[i], 1'b1, 1'b1, rt, 4'b0000, 4'b0000);
      end
      drain();

      // Random back-pressure with random modes and gaps.
      rdy_rand = 1'b1;
      for (int i = 0; i < 500; i++) begin
         r64 = {$urandom, $urandom};
         send(r64[CH*W-1:0], 1'($urandom_range(0, 1)), 1'b0, '0, '0, '0);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      drain();

      // Counter saturation at 15.
      clr_cnt();
      for (int i = 0; i < 6; i++) begin
         send(pack4(11'h400, 11'h400, 11'h400, 11'h400), 1'b0, 1'b0, '0, '0, '0);
      end
      drain();
      chk("cnt_saturate", o_sat_cnt, 4'd15);

      // Clear concurrent with a delivering handshake.
      rdy_dir = 1'b0;
      send(pack4(11'h400, 11'h400, 11'h400, 11'h400), 1'b0, 1'b0, '0, '0, '0);
      @(posedge clk);
      #1;
      chk("clr_hs_valid", o_valid, 1'b1);
      rdy_dir   = 1'b1;
      i_cnt_clr = 1'b1;
      @(posedge clk);
      #1;
      i_cnt_clr = 1'b0;
      chk("clr_hs_cnt", o_sat_cnt, 4'd0);
      chk("clr_hs_pop", q.size(), 0);

      // Make counter non-zero, then reset with two beats in flight.
      send(pack4(11'h400, 11'h001, 11'h002, 11'h003), 1'b0, 1'b0, '0, '0, '0);
      drain();
      chk("pre_rst_cnt", o_sat_cnt, 4'd1);
      rdy_dir = 1'b0;
      send(pack4(11'h123, 11'h7F0, 11'h010, 11'h400), 1'b0, 1'b0, '0, '0, '0);
      send(pack4(11'h456, 11'h001, 11'h402, 11'h000), 1'b1, 1'b0, '0, '0, '0);
      chk("full_ready", o_ready, 1'b0);
      chk("full_valid", o_valid, 1'b1);
      #1;
      i_rst_n = 1'b0;
      #1;
      chk("midrst_valid", o_valid, 1'b0);
      chk("midrst_cnt", o_sat_cnt, '0);
      chk("midrst_data", o_data, '0);
      q.delete();
      cnt_m      = 0;
      stall_prev = 1'b0;
      @(posedge clk);
      #2;
      i_rst_n = 1'b1;
      rdy_dir = 1'b1;
      @(posedge clk);
      #1;
      send(pack4(11'h7FF, 11'h000, 11'h3FF, 11'h401), 1'b0, 1'b1,
           pack4(11'h401, 11'h000, 11'h3FF, 11'h7FF), 4'b0000, 4'b0000);
      @(negedge clk);
      chk("post_rst_lat1", o_valid, 1'b0);
      @(negedge clk);
      chk("post_rst_lat2", o_valid, 1'b1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
